burst_io: RTL and testbench

BURST_IO -- requirements
Module: burst_io

---
 rtl/burst_io_pkg.sv | 25 ++
 rtl/burst_io_if.sv | 38 +++
 rtl/burst_io_addr_gen.sv | 45 ++++
 rtl/burst_io.sv | 138 +++++++++++++
 tb/tb_burst_io.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/burst_io_pkg.sv
// Shared types and helpers for the burst_io register/RAM transfer engine.
// Holds the FSM encoding, RAM direction codes and lane/count width helpers.
package burst_io_pkg;

    localparam logic RAM_READ  = 1'b1;
    localparam logic RAM_WRITE = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_XFER,
        ST_DRAIN,
        ST_DONE
    } state_t;

    // Width of a lane index; never below one bit.
    function automatic int lane_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Width able to hold a word count from 0 to n inclusive.
    function automatic int count_bits(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/burst_io_if.sv
// Request, register-lane and RAM bus signals of burst_io.
// master = requester/RAM side, slave = the burst engine.
interface burst_io_if
    import burst_io_pkg::*;
#(
    parameter int addrBits = 8,
    parameter int dataBits = 16,
    parameter int numRegs  = 4
);
    localparam int LW = lane_bits(numRegs);
    localparam int CW = count_bits(numRegs);

    logic                         start;
    logic                         rw;
    logic [addrBits-1:0]          baseAddr;
    logic [LW-1:0]                firstReg;
    logic [CW-1:0]                count;
    logic [numRegs*dataBits-1:0]  regsIn;
    logic [numRegs*dataBits-1:0]  regsOut;
    logic                         busy;
    logic                         done;
    logic                         error;
    logic [addrBits-1:0]          ramAddr;
    logic [dataBits-1:0]          ramDataIn;
    logic [dataBits-1:0]          ramDataOut;
    logic                         ramRW;

    modport master (
        output start, rw, baseAddr, firstReg, count, regsIn, ramDataOut,
        input  regsOut, busy, done, error, ramAddr, ramDataIn, ramRW
    );

    modport slave (
        input  start, rw, baseAddr, firstReg, count, regsIn, ramDataOut,
        output regsOut, busy, done, error, ramAddr, ramDataIn, ramRW
    );

endinterface

// File: rtl/burst_io_addr_gen.sv
// Word, lane and RAM address counters for one burst.
// addr doubles as the registered ramAddr output and holds once the burst ends.
module burst_io_addr_gen
    import burst_io_pkg::*;
#(
    parameter int addrBits = 8,
    parameter int numRegs  = 4,
    localparam int LW = lane_bits(numRegs),
    localparam int CW = count_bits(numRegs)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load,
    input  logic                adv,
    input  logic [addrBits-1:0] base,
    input  logic [LW-1:0]       first,
    input  logic [CW-1:0]       count,
    output logic [addrBits-1:0] addr,
    output logic [LW-1:0]       lane,
    output logic [LW-1:0]       lane_next,
    output logic                last
);
    logic [CW-1:0] left;

    // Address wraps naturally at 2^addrBits.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr <= '0;
            lane <= '0;
            left <= '0;
        end else if (load) begin
            addr <= base;
            lane <= first;
            left <= count;
        end else if (adv) begin
            addr <= addr + addrBits'(1);
            lane <= lane + LW'(1);
            left <= left - CW'(1);
        end
    end

    assign lane_next = lane + LW'(1);
    assign last      = (left == CW'(1));

endmodule

// File: rtl/burst_io.sv
// Moves a burst of words between a RAM and a bank of top-of-stack register lanes.
// Define IO_BOUNDS_CHECK_EN to reject bursts that would run past the top of RAM.
module burst_io
    import burst_io_pkg::*;
#(
    parameter int addrBits = 8,
    parameter int dataBits = 16,
    parameter int numRegs  = 4
) (
    input  logic       clk,
    input  logic       reset,
    burst_io_if.slave  bus
);
    localparam int LW = lane_bits(numRegs);

    state_t                      state;
    logic                        busy_q, done_q, error_q, ram_rw_q, wr_q;
    logic [dataBits-1:0]         wdata_q;
    logic [numRegs*dataBits-1:0] regs_q;
    logic                        vld_p1;
    logic [LW-1:0]               lane_p1;
    logic [addrBits-1:0]         addr;
    logic [LW-1:0]               lane, lane_next;
    logic                        last;
    logic                        lane_oflow, addr_oflow, reject, load, adv;

    function automatic logic [dataBits-1:0] lane_word(
        input logic [numRegs*dataBits-1:0] v,
        input logic [LW-1:0]               k
    );
        return v[int'(k)*dataBits +: dataBits];
    endfunction

    assign lane_oflow = (int'(bus.firstReg) + int'(bus.count)) > numRegs;

`ifdef IO_BOUNDS_CHECK_EN
    logic [addrBits:0] end_sum;
    // Carry with a non-zero remainder means the last word lies past the top.
    assign end_sum    = {1'b0, bus.baseAddr} + (addrBits+1)'(bus.count);
    assign addr_oflow = end_sum[addrBits] && (end_sum[addrBits-1:0] != '0);
`else
    assign addr_oflow = 1'b0;
`endif

    assign reject = lane_oflow || addr_oflow;
    assign load   = (state == ST_IDLE) && bus.start && !reject && (bus.count != '0);
    assign adv    = (state == ST_XFER) && !last;

    burst_io_addr_gen #(
        .addrBits (addrBits),
        .numRegs  (numRegs)
    ) u_addr_gen (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .adv       (adv),
        .base      (bus.baseAddr),
        .first     (bus.firstReg),
        .count     (bus.count),
        .addr      (addr),
        .lane      (lane),
        .lane_next (lane_next),
        .last      (last)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
            ram_rw_q <= RAM_READ;
            wr_q     <= 1'b0;
            wdata_q  <= '0;
            regs_q   <= '0;
            vld_p1   <= 1'b0;
            lane_p1  <= '0;
        end else begin
            done_q  <= 1'b0;
            error_q <= 1'b0;
            vld_p1  <= 1'b0;
            // Stage p1: read data returns one cycle after its address.
            if (vld_p1)
                regs_q[int'(lane_p1)*dataBits +: dataBits] <= bus.ramDataOut;
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        regs_q <= bus.regsIn;
                        wr_q   <= (bus.rw == RAM_WRITE);
                        busy_q <= 1'b1;
                        if (reject || bus.count == '0) begin
                            state   <= ST_DONE;
                            done_q  <= 1'b1;
                            error_q <= reject;
                        end else begin
                            state    <= ST_XFER;
                            ram_rw_q <= bus.rw;
                            if (bus.rw == RAM_WRITE)
                                wdata_q <= lane_word(bus.regsIn, bus.firstReg);
                        end
                    end
                end
                ST_XFER: begin
                    vld_p1  <= !wr_q;
                    lane_p1 <= lane;
                    if (last) begin
                        ram_rw_q <= RAM_READ;
                        if (wr_q) begin
                            state  <= ST_DONE;
                            done_q <= 1'b1;
                        end else begin
                            state <= ST_DRAIN;
                        end
                    end else if (wr_q) begin
                        wdata_q <= lane_word(regs_q, lane_next);
                    end
                end
                ST_DRAIN: begin
                    state  <= ST_DONE;
                    done_q <= 1'b1;
                end
                ST_DONE: begin
                    state  <= ST_IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.regsOut   = regs_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.error     = error_q;
    assign bus.ramAddr   = addr;
    assign bus.ramDataIn = wdata_q;
    assign bus.ramRW     = ram_rw_q;

endmodule

// File: tb/tb_burst_io.sv
// Randomized bench for burst_io against a cycle-level model of the burst rules.
// RAM is preloaded with mem[k] = 16'hA000 + k and answers reads one cycle late.
module tb_burst_io;
    import burst_io_pkg::*;

    localparam int AW = 8;
    localparam int DW = 16;
    localparam int NR = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    burst_io_if #(.addrBits(AW), .dataBits(DW), .numRegs(NR)) bus();

    burst_io #(.addrBits(AW), .dataBits(DW), .numRegs(NR)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [15:0] mem [256];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          wr_seen = 0;
    bit          mon_en  = 1'b0;
    logic [7:0]  last_addr_m = 8'd0;

    always @(posedge clk) bus.ramDataOut <= mem[bus.ramAddr];
    always @(posedge clk) if (mon_en && bus.ramRW == RAM_WRITE) wr_seen <= wr_seen + 1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, " busy"},      64'(bus.busy),      64'd0);
        check_eq({tag, " done"},      64'(bus.done),      64'd0);
        check_eq({tag, " error"},     64'(bus.error),     64'd0);
        check_eq({tag, " regsOut"},   64'(bus.regsOut),   64'd0);
        check_eq({tag, " ramAddr"},   64'(bus.ramAddr),   64'd0);
        check_eq({tag, " ramDataIn"}, 64'(bus.ramDataIn), 64'd0);
        check_eq({tag, " ramRW"},     64'(bus.ramRW),     64'(RAM_READ));
    endtask

    // Caller is at a falling edge with start low and the DUT idle.
    task automatic run_burst(input string name, input bit wr, input logic [7:0] base,
                             input int first, input int cnt, input logic [63:0] regs,
                             input bit noise);
        bit          err, acc;
        int          d;
        logic [7:0]  a;
        logic [63:0] exp_regs;
        err = (first + cnt > NR);
`ifdef IO_BOUNDS_CHECK_EN
        if (cnt > 0 && int'(base) + cnt - 1 > 255) err = 1'b1;
`endif
        acc = !err && cnt > 0;
        d   = !acc ? 1 : (wr ? cnt + 1 : cnt + 2);
        exp_regs = regs;
        if (acc && !wr)
            for (int i = 0; i < cnt; i++) begin
                a = base + 8'(i);
                exp_regs[(first + i)*16 +: 16] = mem[a];
            end

        bus.start    = 1'b1;
        bus.rw       = wr ? RAM_WRITE : RAM_READ;
        bus.baseAddr = base;
        bus.firstReg = 2'(first);
        bus.count    = 3'(cnt);
        bus.regsIn   = regs;

        for (int c = 1; c <= d + 1; c++) begin
            @(negedge clk);
            check_eq($sformatf("%s c%0d busy", name, c),  64'(bus.busy),  64'(c <= d));
            check_eq($sformatf("%s c%0d done", name, c),  64'(bus.done),  64'(c == d));
            check_eq($sformatf("%s c%0d error", name, c), 64'(bus.error), 64'(err && c == d));
            check_eq($sformatf("%s c%0d ramRW", name, c), 64'(bus.ramRW),
                     64'((acc && wr && c <= cnt) ? RAM_WRITE : RAM_READ));
            if (acc && c <= cnt) begin
                a = base + 8'(c - 1);
                check_eq($sformatf("%s c%0d ramAddr", name, c), 64'(bus.ramAddr), 64'(a));
                if (wr)
                    check_eq($sformatf("%s c%0d ramDataIn", name, c), 64'(bus.ramDataIn),
                             64'(regs[(first + c - 1)*16 +: 16]));
            end else if (!acc) begin
                check_eq($sformatf("%s c%0d ramAddr held", name, c), 64'(bus.ramAddr),
                         64'(last_addr_m));
            end
            if (noise && c < d) begin
                bus.start    = 1'($urandom);
                bus.rw       = 1'($urandom);
                bus.baseAddr = 8'($urandom);
                bus.firstReg = 2'($urandom);
                bus.count    = 3'($urandom_range(0, 4));
                bus.regsIn   = {$urandom, $urandom};
            end else begin
                bus.start = 1'b0;
            end
        end
        check_eq({name, " regsOut"}, bus.regsOut, exp_regs);
        if (acc) last_addr_m = base + 8'(cnt - 1);
    endtask

    initial begin
        for (int k = 0; k < 256; k++) mem[k] = 16'hA000 + 16'(k);
        reset        = 1'b0;
        bus.start    = 1'b0;
        bus.rw       = RAM_READ;
        bus.baseAddr = '0;
        bus.firstReg = '0;
        bus.count    = '0;
        bus.regsIn   = '0;
        repeat (3) @(negedge clk);
        check_reset_vals("por");
        reset = 1'b1;
        @(negedge clk);

        run_burst("rd13",   1'b0, 8'd13,  0, 3, 64'h4444_3333_2222_1111, 1'b1);
        run_burst("wr20",   1'b1, 8'd20,  1, 2, 64'h4444_2222_1111_0000, 1'b1);
        run_burst("lane_r", 1'b0, 8'd50,  3, 2, 64'h0123_4567_89AB_CDEF, 1'b0);
        run_burst("lane_w", 1'b1, 8'd60,  3, 2, 64'h0123_4567_89AB_CDEF, 1'b0);
        run_burst("top_r",  1'b0, 8'd255, 0, 2, 64'h5555_6666_7777_8888, 1'b1);
        run_burst("top_w",  1'b1, 8'd255, 2, 2, 64'h5555_6666_7777_8888, 1'b1);
        run_burst("zero",   1'b1, 8'd7,   2, 0, 64'h9999_AAAA_BBBB_CCCC, 1'b0);
        run_burst("full_r", 1'b0, 8'd100, 0, 4, 64'hDEAD_BEEF_CAFE_F00D, 1'b1);

        for (int n = 0; n < 40; n++) begin
            logic [7:0] b;
            b = ($urandom_range(0, 3) == 0) ? 8'(252 + $urandom_range(0, 3)) : 8'($urandom);
            run_burst($sformatf("rnd%0d", n), 1'($urandom), b, $urandom_range(0, 3),
                      $urandom_range(0, 4), {$urandom, $urandom}, 1'b1);
        end

        // Abort a 4-word write early in its second cycle.
        bus.start    = 1'b1;
        bus.rw       = RAM_WRITE;
        bus.baseAddr = 8'd40;
        bus.firstReg = 2'd0;
        bus.count    = 3'd4;
        bus.regsIn   = 64'h1234_5678_9ABC_DEF1;
        @(negedge clk);
        bus.rw       = RAM_READ;
        bus.baseAddr = 8'd99;
        bus.count    = 3'd1;
        check_eq("abort c1 busy",    64'(bus.busy),      64'd1);
        check_eq("abort c1 ramRW",   64'(bus.ramRW),     64'(RAM_WRITE));
        check_eq("abort c1 ramAddr", 64'(bus.ramAddr),   64'd40);
        check_eq("abort c1 data",    64'(bus.ramDataIn), 64'hDEF1);
        @(posedge clk);
        #1;
        check_eq("abort c2 ramAddr", 64'(bus.ramAddr),   64'd41);
        check_eq("abort c2 ramRW",   64'(bus.ramRW),     64'(RAM_WRITE));
        #1;
        mon_en = 1'b1;
        reset  = 1'b0;
        #1;
        check_reset_vals("abort async");
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        last_addr_m = 8'd0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check_eq($sformatf("post c%0d busy", c),  64'(bus.busy),  64'd0);
            check_eq($sformatf("post c%0d ramRW", c), 64'(bus.ramRW), 64'(RAM_READ));
        end
        mon_en = 1'b0;
        check_eq("abort writes after reset", 64'(wr_seen), 64'd0);
        run_burst("recover", 1'b0, 8'd3, 1, 3, 64'h1111_2222_3333_4444, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
